// File: rtl/logic_unit_iter.sv
// rtl/logic_unit_iter.sv - iterative sliced bitwise logic unit with popcount and zero flag
// Evaluates one SLICE-bit chunk of f_op(a, b) per RUN cycle; results publish only on RUN->DONE.
module logic_unit_iter #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [CW-1:0]    ones,
  output logic             zero
);

  localparam int N  = WIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 1 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_param
    $error("logic_unit_iter: WIDTH must be >=1 and a multiple of SLICE");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]    ones_q, ones_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] word;
  logic [SLICE-1:0] slice_res;
  logic [CW-1:0]    slice_pc;
  int               base;

  // Whole-word function; only the slice selected by idx_q is consumed each cycle.
  always_comb begin
    word = '0;
    case (op_q)
      3'd0:    word = a_q & b_q;
      3'd1:    word = a_q | b_q;
      3'd2:    word = a_q ^ b_q;
      3'd3:    word = ~(a_q ^ b_q);
      3'd4:    word = ~(a_q & b_q);
      3'd5:    word = ~(a_q | b_q);
      3'd6:    word = a_q & ~b_q;
      default: word = a_q;
    endcase
    base      = int'(idx_q) * SLICE;
    slice_res = word[base +: SLICE];
    slice_pc  = '0;
    for (int i = 0; i < SLICE; i++) begin
      slice_pc = slice_pc + CW'(slice_res[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    ones_d  = ones_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          res_d   = '0;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[base +: SLICE] = slice_res;
        cnt_d = cnt_q + slice_pc;
        if (idx_q == IW'(N - 1)) begin
          // Publish including this cycle's slice so the final chunk is not lost.
          out_d   = res_d;
          ones_d  = cnt_d;
          zero_d  = (cnt_d == '0);
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      ones_q  <= '0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      ones_q  <= ones_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign ones      = ones_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_logic_unit_iter.sv
// tb/tb_logic_unit_iter.sv - self-checking bench for logic_unit_iter at three parameter points
// Instances: 0 = 32/8 (N=4), 1 = 64/64 (N=1), 2 = 8/1 (N=8).
module tb_logic_unit_iter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [63:0] a_s [3];
  logic [63:0] b_s [3];
  logic [2:0]  op_s [3];
  logic        iv [3];
  logic        ordy [3];
  logic        ir [3];
  logic        ov [3];

  logic [31:0] out0;
  logic [63:0] out1;
  logic [7:0]  out2;
  logic [5:0]  ones0;
  logic [6:0]  ones1;
  logic [3:0]  ones2;
  logic        zero0, zero1, zero2;

  int checks   = 0;
  int failures = 0;
  int excl_err = 0;
  int wd [3]   = '{32, 64, 8};
  int nn [3]   = '{4, 1, 8};

  logic_unit_iter #(.WIDTH(32), .SLICE(8)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .op(op_s[0]),
    .a(a_s[0][31:0]), .b(b_s[0][31:0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out(out0), .ones(ones0), .zero(zero0));

  logic_unit_iter #(.WIDTH(64), .SLICE(64)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .op(op_s[1]),
    .a(a_s[1]), .b(b_s[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out(out1), .ones(ones1), .zero(zero1));

  logic_unit_iter #(.WIDTH(8), .SLICE(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .op(op_s[2]),
    .a(a_s[2][7:0]), .b(b_s[2][7:0]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .out(out2), .ones(ones2), .zero(zero2));

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (ir[i] && ov[i]) excl_err++;
      end
    end
  end

  function automatic logic [63:0] get_out(input int i);
    case (i)
      0:       return {32'b0, out0};
      1:       return out1;
      default: return {56'b0, out2};
    endcase
  endfunction

  function automatic logic [63:0] get_ones(input int i);
    case (i)
      0:       return {58'b0, ones0};
      1:       return {57'b0, ones1};
      default: return {60'b0, ones2};
    endcase
  endfunction

  function automatic logic get_zero(input int i);
    case (i)
      0:       return zero0;
      1:       return zero1;
      default: return zero2;
    endcase
  endfunction

  function automatic logic [63:0] model(input int w, input logic [63:0] x, input logic [63:0] y,
                                        input logic [2:0] f);
    logic [63:0] r;
    logic [63:0] m;
    m = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    case (f)
      3'd0:    r = x & y;
      3'd1:    r = x | y;
      3'd2:    r = x ^ y;
      3'd3:    r = ~(x ^ y);
      3'd4:    r = ~(x & y);
      3'd5:    r = ~(x | y);
      3'd6:    r = x & ~y;
      default: r = x;
    endcase
    return r & m;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic start_op(input int i, input logic [63:0] av, input logic [63:0] bv,
                          input logic [2:0] f);
    int t = 0;
    while (!ir[i] && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 200) chk("start_timeout", 64'(t), 64'd0);
    a_s[i] = av; b_s[i] = bv; op_s[i] = f; iv[i] = 1'b1;
    @(posedge clk); #1;
    iv[i] = 1'b0;
    a_s[i] = {$urandom, $urandom}; b_s[i] = {$urandom, $urandom}; op_s[i] = 3'($urandom);
  endtask

  task automatic wait_valid(input int i, output int lat);
    lat = 0;
    while (!ov[i] && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    if (lat >= 200) chk("valid_timeout", 64'(lat), 64'd0);
  endtask

  task automatic pop(input int i);
    ordy[i] = 1'b1;
    @(posedge clk); #1;
    ordy[i] = 1'b0;
  endtask

  task automatic run_check(input int i, input logic [63:0] av, input logic [63:0] bv,
                           input logic [2:0] f, input string tag);
    int lat;
    logic [63:0] e;
    e = model(wd[i], av, bv, f);
    start_op(i, av, bv, f);
    wait_valid(i, lat);
    chk({tag, "_lat"}, 64'(lat), 64'(nn[i]));
    chk({tag, "_out"}, get_out(i), e);
    chk({tag, "_ones"}, get_ones(i), 64'($countones(e)));
    chk({tag, "_zero"}, 64'(get_zero(i)), 64'(e == 64'd0));
    pop(i);
  endtask

  task automatic reset_state(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_out"}, get_out(i), 64'd0);
      chk({tag, "_ones"}, get_ones(i), 64'd0);
      chk({tag, "_zero"}, 64'(get_zero(i)), 64'd1);
      chk({tag, "_valid"}, 64'(ov[i]), 64'd0);
      chk({tag, "_ready"}, 64'(ir[i]), 64'd1);
    end
  endtask

  task automatic b2b(input int i, input logic [63:0] av, input logic [63:0] bv, input logic [2:0] f);
    int prev = -1;
    int seen = 0;
    logic [63:0] e;
    e = model(wd[i], av, bv, f);
    a_s[i] = av; b_s[i] = bv; op_s[i] = f; iv[i] = 1'b1; ordy[i] = 1'b1;
    for (int c = 1; c <= 5 * (nn[i] + 2) + 4; c++) begin
      @(posedge clk); #1;
      if (ov[i]) begin
        if (prev >= 0) chk("b2b_spacing", 64'(c - prev), 64'(nn[i] + 2));
        chk("b2b_out", get_out(i), e);
        prev = c;
        seen++;
      end
    end
    chk("b2b_count_ok", 64'(seen >= 4), 64'd1);
    iv[i] = 1'b0;
    for (int c = 0; c < 20 && !ir[i]; c++) begin
      @(posedge clk); #1;
    end
    ordy[i] = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] exp_out;
    int          exp_ones;
    logic        exp_zero;
  } vec_t;

  initial begin
    vec_t tbl [8];
    int lat;
    logic [63:0] held;
    logic [63:0] e;
    logic [63:0] ra, rb;
    logic [2:0]  rf;

    tbl[0] = '{32'hF0F0_1234, 32'h0FF0_1234, 3'd2, 32'hFF00_0000, 8,  1'b0};
    tbl[1] = '{32'hAAAA_AAAA, 32'h5555_5555, 3'd0, 32'h0000_0000, 0,  1'b1};
    tbl[2] = '{32'hAAAA_AAAA, 32'h5555_5555, 3'd1, 32'hFFFF_FFFF, 32, 1'b0};
    tbl[3] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'd3, 32'hFFFF_FFFF, 32, 1'b0};
    tbl[4] = '{32'hFFFF_0000, 32'h0F0F_0F0F, 3'd6, 32'hF0F0_0000, 8,  1'b0};
    tbl[5] = '{32'hAAAA_AAAA, 32'h5555_5555, 3'd4, 32'hFFFF_FFFF, 32, 1'b0};
    tbl[6] = '{32'hAAAA_AAAA, 32'h5555_5555, 3'd5, 32'h0000_0000, 0,  1'b1};
    tbl[7] = '{32'h1234_5678, 32'hFFFF_FFFF, 3'd7, 32'h1234_5678, 13, 1'b0};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_s[i] = '0; b_s[i] = '0; op_s[i] = '0; iv[i] = 1'b0; ordy[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset_state("reset");
    rst_n = 1'b1;

    for (int k = 0; k < 8; k++) begin
      start_op(0, {32'b0, tbl[k].a}, {32'b0, tbl[k].b}, tbl[k].op);
      wait_valid(0, lat);
      chk($sformatf("vec%0d_lat", k), 64'(lat), 64'd4);
      chk($sformatf("vec%0d_out", k), get_out(0), {32'b0, tbl[k].exp_out});
      chk($sformatf("vec%0d_ones", k), get_ones(0), 64'(tbl[k].exp_ones));
      chk($sformatf("vec%0d_zero", k), 64'(get_zero(0)), 64'(tbl[k].exp_zero));
      pop(0);
    end

    run_check(1, {64{1'b1}}, 64'd0, 3'd2, "n1_xor");
    run_check(2, 64'hA5, 64'h0F, 3'd2, "n8_xor");

    for (int k = 0; k < 30; k++) begin
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rf = 3'($urandom_range(0, 7));
      run_check(k % 3, ra, rb, rf, $sformatf("rand%0d", k));
    end

    // Backpressure: DONE held while a new request waits at the input.
    start_op(0, 64'h1357_9BDF, 64'h0F0F_F0F0, 3'd2);
    wait_valid(0, lat);
    held = get_out(0);
    chk("bp_first_out", held, model(32, 64'h1357_9BDF, 64'h0F0F_F0F0, 3'd2));
    a_s[0] = 64'hCAFE_F00D; b_s[0] = 64'h0FF0_0FF0; op_s[0] = 3'd0; iv[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_valid", 64'(ov[0]), 64'd1);
      chk("bp_out", get_out(0), held);
      chk("bp_ready", 64'(ir[0]), 64'd0);
    end
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    chk("bp_idle_ready", 64'(ir[0]), 64'd1);
    chk("bp_idle_valid", 64'(ov[0]), 64'd0);
    chk("bp_idle_out_hold", get_out(0), held);
    @(posedge clk); #1;
    iv[0] = 1'b0;
    chk("bp_accepted", 64'(ir[0]), 64'd0);
    wait_valid(0, lat);
    e = model(32, 64'hCAFE_F00D, 64'h0FF0_0FF0, 3'd0);
    chk("bp_second_lat", 64'(lat), 64'd4);
    chk("bp_second_out", get_out(0), e);
    chk("bp_second_ones", get_ones(0), 64'($countones(e)));
    pop(0);

    // Reset after E2 of an in-flight op.
    start_op(0, 64'hFFFF_FFFF, 64'h0, 3'd1);
    @(posedge clk);
    @(posedge clk); #1;
    iv[0] = 1'b1;
    rst_n = 1'b0;
    #1;
    reset_state("midrun_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("post_reset_ready", 64'(ir[0]), 64'd1);
    iv[0] = 1'b0;
    run_check(0, 64'h0000_FFFF, 64'h00FF_00FF, 3'd2, "post_reset");

    b2b(0, 64'h89AB_CDEF, 64'h0123_4567, 3'd2);
    b2b(1, 64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000, 3'd6);

    chk("excl_ready_valid", 64'(excl_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/logic_unit_iter.md
# logic_unit_iter

Parametrised, iterative bitwise logic unit; the next-generation replacement for the fixed 32-bit XOR block. Accepts two WIDTH-bit operands and a 3-bit op code over a valid/ready handshake. Evaluates the result SLICE bits per clock and returns it with a population count and zero flag over a second valid/ready handshake. It sits between the register-file read stage and writeback in the ALU datapath, alongside the other multi-cycle units.

## Interface
- WIDTH, 32, operand/result width in bits; ≥1
- SLICE, 8, bits evaluated per RUN cycle; WIDTH % SLICE must be 0; elaboration error otherwise
- Derived: N = WIDTH/SLICE; CW = $clog2(WIDTH+1)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand request
- in_ready  out  1  unit can accept; = (state==IDLE)
- op  in  3  0 AND, 1 OR, 2 XOR, 3 XNOR, 4 NAND, 5 NOR, 6 ANDN (a & ~b), 7 PASS (a)
- a, b  in  WIDTH  operands
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out  out  WIDTH  result
- ones  out  CW  number of 1 bits in out
- zero  out  1  out == 0

## Operation
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch a, b and op into internal registers.
  - Clear the result accumulator and the popcount accumulator; idx←0; go to RUN.
  - Inputs are don't-care once latched.
- RUN:
  - Each cycle: res[idx*SLICE +: SLICE] ← f_op(a_q, b_q) on that slice; cnt ← cnt + popcount(slice result); idx←idx+1.
  - When idx==N-1: copy the final res into out, cnt into ones, (cnt==0) into zero; go to DONE.
  - The copy includes the current cycle's slice.
- DONE:
  - out_valid=1.
  - On out_ready, go to IDLE.
  - out, ones and zero are stable until the next completion.
- in_valid is ignored outside IDLE. No request is queued.
- in_ready is low in RUN and DONE.
- out_ready is ignored outside DONE.
- out, ones and zero change only on the RUN→DONE edge. Between results they hold the last completed values.
- ones is exact for all WIDTH: CW bits, no saturation. Popcount of all-ones is WIDTH.
- N=1: RUN lasts exactly one cycle.
- Reset (rst_n low, any state, including mid-RUN):
  - State→IDLE; idx, accumulators and latched operands←0.
  - out←0, ones←0, zero←1, out_valid←0.
  - in_ready=1 from state decode, but no transfer occurs while rst_n is low.
  - An in-flight operation is discarded, with no partial result.

## Timing
- Accept edge E0 (in_valid&&in_ready sampled high).
- Slices are processed on edges E1..EN.
- out_valid is high after edge EN, so latency is N edges after accept. Default: 4.
- out_valid and in_ready are never high in the same cycle.
- Minimum turnaround is N+2 cycles per operation, with out_ready held high: DONE lasts 1 cycle, then IDLE lasts 1 cycle.
- With out_ready low, DONE is held indefinitely; out, ones, zero and out_valid stay stable.
- All outputs are registered or pure state decode; no combinational path exists from inputs to outputs.

## Test plan
- XOR, defaults:
  - Stimulus: a=0xF0F0_1234, b=0x0FF0_1234, op=2.
  - Response: out_valid after 4 edges; out=0xFF00_0000, ones=8, zero=0.
- Op sweep on fixed operands:
  - a=0xAAAA_AAAA, b=0x5555_5555, AND → out=0, ones=0, zero=1.
  - Same operands, OR → 0xFFFF_FFFF, ones=32.
  - a=b=0xDEAD_BEEF, XNOR → 0xFFFF_FFFF.
  - a=0xFFFF_0000, b=0x0F0F_0F0F, ANDN → 0xF0F0_0000, ones=8.
  - Also check NAND, NOR and PASS against a software model.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles in DONE; assert in_valid with new operands throughout.
  - Response: out_valid stays 1, out is unchanged, in_ready=0, and no second accept occurs.
  - Then raise out_ready: IDLE on the next edge, and the pending request is accepted on the following edge.
- Reset mid-RUN:
  - Stimulus: assert rst_n=0 after E2.
  - Response: outputs immediately out=0, ones=0, zero=1, out_valid=0.
  - After release, a fresh op completes with full latency and a correct result.
- Parameter corners:
  - WIDTH=64, SLICE=64 (N=1), XOR of 0xFFFF…F with 0 → out_valid after 1 edge, ones=64.
  - WIDTH=8, SLICE=1 (N=8) → latency 8 edges.
  - Back-to-back ops with out_ready=1 → one result every N+2 cycles.
